// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block/length widths, padder state encoding
// and the byte-lane offset helper also used by the core's word slicing.
package sha256_pkg;

  localparam int BLOCK_W = 512;
  localparam int LEN_W   = 64;

  typedef enum logic [2:0] {
    S_FILL      = 3'd0,
    S_FULL_OUT  = 3'd1,
    S_PAD       = 3'd2,
    S_EXTRA_OUT = 3'd3,
    S_LAST_OUT  = 3'd4
  } padder_state_t;

  // LSB of byte lane idx; lane 0 sits in bits [511:504]
  function automatic logic [8:0] lane_lsb(input logic [5:0] idx);
    return 9'd504 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-in / block-out stream bundle between the message source, the padder
// and the compression core.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_byte;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               out_first;
  logic               out_last;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_first, out_last
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_block, out_first, out_last
  );

endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
//
// state       | meaning
// S_FILL      | accepting message bytes into lane ptr
// S_FULL_OUT  | presenting a full data block (more data or padding follows)
// S_PAD       | one cycle: insert 0x80, zero the tail, add length if it fits
// S_EXTRA_OUT | presenting a block whose tail had no room for the length
// S_LAST_OUT  | presenting the final block carrying the length
module sha256_padder
  import sha256_pkg::*;
(
  input logic            clk,
  input logic            rst,
  sha256_padder_if.slave bus
);

  padder_state_t      state, state_d;
  logic [BLOCK_W-1:0] blk;
  logic [BLOCK_W-1:0] pad_blk;
  logic [5:0]         ptr;
  logic [60:0]        bcnt;
  logic [LEN_W-1:0]   len;
  logic               first_flag;
  logic               pad_pend;
  logic               run;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               out_last_c;
  logic               take;
  logic               xfer;

  // run keeps in_ready low while reset is asserted even though state is FILL
  assign in_ready_c = run && (state == S_FILL);
  assign take       = bus.in_valid && in_ready_c;
  assign xfer       = out_valid_c && bus.out_ready;
  assign len        = {bcnt, 3'b000};

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_first = out_valid_c && first_flag;
  assign bus.out_block = blk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FILL;
    else      state <= state_d;
  end

  always_comb begin
    state_d     = state;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    case (state)
      S_FILL: begin
        if (take && ptr == 6'd63)  state_d = S_FULL_OUT;
        else if (take && bus.in_last) state_d = S_PAD;
      end
      S_FULL_OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = pad_pend ? S_PAD : S_FILL;
      end
      S_PAD: begin
        state_d = (ptr <= 6'd55) ? S_LAST_OUT : S_EXTRA_OUT;
      end
      S_EXTRA_OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = S_LAST_OUT;
      end
      S_LAST_OUT: begin
        out_valid_c = 1'b1;
        out_last_c  = 1'b1;
        if (bus.out_ready) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    pad_blk = blk;
    for (int i = 0; i < 64; i++) begin
      if (i > int'(ptr)) pad_blk[lane_lsb(6'(i)) +: 8] = 8'h00;
    end
    pad_blk[lane_lsb(ptr) +: 8] = 8'h80;
    if (ptr <= 6'd55) pad_blk[LEN_W-1:0] = len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk        <= '0;
      ptr        <= '0;
      bcnt       <= '0;
      first_flag <= 1'b1;
      pad_pend   <= 1'b0;
      run        <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FILL: begin
          if (take) begin
            blk[lane_lsb(ptr) +: 8] <= bus.in_byte;
            ptr  <= ptr + 6'd1;
            bcnt <= bcnt + 61'd1;
            if (ptr == 6'd63) pad_pend <= bus.in_last;
          end
        end
        S_FULL_OUT: begin
          if (xfer) begin
            blk        <= '0;
            ptr        <= '0;
            first_flag <= 1'b0;
          end
        end
        S_PAD: blk <= pad_blk;
        S_EXTRA_OUT: begin
          if (xfer) begin
            blk        <= {{(BLOCK_W-LEN_W){1'b0}}, len};
            first_flag <= 1'b0;
          end
        end
        S_LAST_OUT: begin
          if (xfer) begin
            blk        <= '0;
            ptr        <= '0;
            bcnt       <= '0;
            first_flag <= 1'b1;
            pad_pend   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message front end for the SHA-256 core. Accepts an arbitrary-length message as a byte stream with valid/ready handshake. Applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and emits 512-bit blocks in the exact layout the compression core loads: first message byte in bits [511:504], word 0 in [511:480].

## Interface
- No parameters; all widths are fixed by SHA-256.
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  padder accepts a byte this cycle
- in_byte  input  8  message byte, in stream order
- in_last  input  1  qualifies the final byte of the message
- out_valid  output  1  out_block holds a complete block
- out_ready  input  1  downstream takes the block
- out_block  output  512  padded block, big-endian byte order
- out_first  output  1  block is the first of its message; downstream reloads the H constants
- out_last  output  1  block is the final block of its message; digest is valid after it

## Operation
- States: FILL, FULL_OUT, PAD, EXTRA_OUT, LAST_OUT. Reset state is FILL.
- FILL: in_ready=1.
  - Byte accepted on in_valid&in_ready is written to lane ptr (bits [511-8*ptr -: 8]).
  - ptr (6 bits) increments. Byte counter bcnt (61 bits) increments.
- FILL, in_last=0, ptr==63: go to FULL_OUT with pad_pend=0.
- FILL, in_last=1, ptr<63: go to PAD.
- FILL, in_last=1, ptr==63: go to FULL_OUT with pad_pend=1.
- FULL_OUT: out_valid=1 and out_last=0. On handshake:
  - ptr←0 and the buffer clears.
  - If pad_pend, go to PAD; otherwise go to FILL.
- PAD (one cycle): write 0x80 at lane ptr and zero all lanes above ptr.
  - If ptr≤55, write length L into bits [63:0] and go to LAST_OUT.
  - Otherwise go to EXTRA_OUT.
- EXTRA_OUT: out_valid=1, out_last=0. On handshake, the buffer becomes all-zero with L in bits [63:0], then go to LAST_OUT.
- LAST_OUT: out_valid=1, out_last=1. On handshake, clear bcnt, ptr and buffer, set first_flag, and go to FILL.
- Length: L = {bcnt, 3'b000}, 64 bits, big-endian. It is computed from bcnt including the final byte. Wraps modulo 2^64 (no overflow detection).
- out_first is 1 on the first emitted block after reset or after a LAST_OUT handshake. It clears after that block's handshake.
- Zero-length messages are not supported: in_last is always qualified by a byte.
- out_block, out_first and out_last are stable while out_valid=1 && out_ready=0.
- in_ready=0 in every state except FILL. Bytes presented there are not consumed.

## Timing
- Reset values:
  - out_valid=0, out_block=0, out_first=0, out_last=0, in_ready=0 while rst low.
  - Internally: state=FILL, ptr=0, bcnt=0, first_flag=1, pad_pend=0.
- Reset is honoured at any point, including mid-message or mid-output. The partial block is discarded and no out_valid pulse follows.
- Throughput: one byte per cycle in FILL.
- Full block: 64th byte accepted at edge N → out_valid high from N (registered, visible in cycle N+1).
- Final block: last byte accepted at edge N → PAD during cycle N+1 → out_valid high after edge N+1.
  - Extra length block: out_valid re-asserts in the cycle after the EXTRA_OUT handshake.
- Output handshake: transfer on out_valid&out_ready at a rising edge. out_valid never drops without a transfer.
- No combinational path from out_ready to in_ready. in_ready depends only on state.

## Structure
- Shared package sha256_pkg holds:
  - BLOCK_W=512, LEN_W=64, padder state enum.
  - Byte-lane offset helper function, shared with the core's word slicing.
- No sub-module; the buffer, counters and FSM form a single module of about 200 lines.

## Test plan
- "abc" (0x61,0x62,0x63, in_last on 0x63) → one block: 0x61626380, then zeros, then bits [63:0]=0x18. out_first=1, out_last=1.
- 55-byte message of 0x00 → one block: byte 55=0x80, [63:0]=0x1B8, out_first=out_last=1.
- 56-byte message → two blocks:
  - First: byte 56=0x80 then zeros, out_first=1, out_last=0.
  - Second: all zero except [63:0]=0x1C0, out_last=1.
- 64-byte message (in_last on byte 63) → data block (FULL_OUT), then a block with byte 0=0x80 and [63:0]=0x200, out_last=1.
- Backpressure: out_ready held low 10 cycles during LAST_OUT → out_block/out_last stable, in_ready=0, no bytes consumed. Then out_ready=1 → single transfer, then return to FILL.
- rst pulsed low after 20 bytes → outputs reach reset values asynchronously. Then "abc" → the same digest block as scenario 1 with out_first=1.
